// File: rtl/dff_pipe_param.sv
// WIDTH x DEPTH register pipeline with per-stage valid, clock enable, sync clear,
// hold/shift/load/rotate modes, a selectable tap and a registered occupancy count.
module dff_pipe_param #(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int              TW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int              CW        = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic [TW-1:0]    tap_sel,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic [WIDTH-1:0] tap_out,
   output logic             tap_valid,
   output logic [CW-1:0]    count
);

   typedef enum logic [1:0] {
      MODE_HOLD   = 2'b00,
      MODE_SHIFT  = 2'b01,
      MODE_LOAD   = 2'b10,
      MODE_ROTATE = 2'b11
   } mode_e;

   logic [DEPTH-1:0][WIDTH-1:0] data_p0;
   logic [DEPTH-1:0][WIDTH-1:0] data_nxt;
   logic [DEPTH-1:0]            vld_p0;
   logic [DEPTH-1:0]            vld_nxt;
   logic [CW-1:0]               count_p0;

   function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] bits);
      logic [CW-1:0] n;
      n = '0;
      for (int i = 0; i < DEPTH; i++) n = n + CW'(bits[i]);
      return n;
   endfunction

   always_comb begin
      data_nxt = data_p0;
      vld_nxt  = vld_p0;
      if (en) begin
         case (mode_e'(mode))
            MODE_SHIFT: begin
               data_nxt[0] = din;
               vld_nxt[0]  = din_valid;
               for (int i = 1; i < DEPTH; i++) begin
                  data_nxt[i] = data_p0[i-1];
                  vld_nxt[i]  = vld_p0[i-1];
               end
            end
            MODE_LOAD: begin
               data_nxt = {DEPTH{din}};
               vld_nxt  = {DEPTH{din_valid}};
            end
            MODE_ROTATE: begin
               data_nxt[0] = data_p0[DEPTH-1];
               vld_nxt[0]  = vld_p0[DEPTH-1];
               for (int i = 1; i < DEPTH; i++) begin
                  data_nxt[i] = data_p0[i-1];
                  vld_nxt[i]  = vld_p0[i-1];
               end
            end
            default: ;
         endcase
      end
   end

   // Stage register: count is taken from the next valid vector so it never lags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_p0  <= {DEPTH{RESET_VAL}};
         vld_p0   <= '0;
         count_p0 <= '0;
      end else if (clr) begin
         data_p0  <= {DEPTH{RESET_VAL}};
         vld_p0   <= '0;
         count_p0 <= '0;
      end else begin
         data_p0  <= data_nxt;
         vld_p0   <= vld_nxt;
         count_p0 <= popcount(vld_nxt);
      end
   end

   // Out-of-range tap selects fall through to zero rather than indexing past the array.
   always_comb begin
      tap_out   = '0;
      tap_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (tap_sel == TW'(i)) begin
            tap_out   = data_p0[i];
            tap_valid = vld_p0[i];
         end
      end
   end

   assign dout       = data_p0[DEPTH-1];
   assign dout_valid = vld_p0[DEPTH-1];
   assign count      = count_p0;

endmodule

// File: tb/tb_dff_pipe_param.sv
// Bench for dff_pipe_param: DEPTH=4, 3 and 1 instances driven in parallel,
// directed vector table, hand sequences and randomized traffic against a model.
module tb_dff_pipe_param;

   localparam logic [1:0] HO = 2'b00, SH = 2'b01, LD = 2'b10, RO = 2'b11;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0, clr = 1'b0, din_valid = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [7:0] din = 8'h00;
   logic [1:0] tsel4 = 2'd0, tsel3 = 2'd0;
   logic       tsel1 = 1'b0;

   logic [7:0] dout4, tap4, dout3, tap3, dout1, tap1;
   logic       dv4, tv4, dv3, tv3, dv1, tv1;
   logic [2:0] cnt4;
   logic [1:0] cnt3;
   logic       cnt1;

   int n_tests = 0;
   int n_fail  = 0;

   dff_pipe_param #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u_d4 (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .din(din),
      .din_valid(din_valid), .tap_sel(tsel4), .dout(dout4), .dout_valid(dv4),
      .tap_out(tap4), .tap_valid(tv4), .count(cnt4));

   dff_pipe_param #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h3C)) u_d3 (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .din(din),
      .din_valid(din_valid), .tap_sel(tsel3), .dout(dout3), .dout_valid(dv3),
      .tap_out(tap3), .tap_valid(tv3), .count(cnt3));

   dff_pipe_param #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'hC5)) u_d1 (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .din(din),
      .din_valid(din_valid), .tap_sel(tsel1), .dout(dout1), .dout_valid(dv1),
      .tap_out(tap1), .tap_valid(tv1), .count(cnt1));

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Reference model: one stage list per instance, updated per the mode rules.
   logic [7:0] ms[3][4];
   logic       mv[3][4];
   int         dep[3] = '{4, 3, 1};
   logic [7:0] rv[3]  = '{8'h00, 8'h3C, 8'hC5};

   typedef struct {
      logic       c, e;
      logic [1:0] m;
      logic [7:0] d;
      logic       dv;
      logic [1:0] ts;
      logic [7:0] x_dout;
      logic       x_dv;
      logic [7:0] x_tap;
      logic       x_tv;
      int         x_cnt;
   } vec_t;
   vec_t tbl[19];

   task automatic model_reset();
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 4; i++) begin
            ms[k][i] = rv[k];
            mv[k][i] = 1'b0;
         end
   endtask

   task automatic model_step();
      logic [7:0] td;
      logic       tv;
      if (!rst_n || clr) model_reset();
      else if (en) begin
         for (int k = 0; k < 3; k++) begin
            case (mode)
               SH: begin
                  for (int i = dep[k] - 1; i > 0; i--) begin
                     ms[k][i] = ms[k][i-1];
                     mv[k][i] = mv[k][i-1];
                  end
                  ms[k][0] = din;
                  mv[k][0] = din_valid;
               end
               LD: for (int i = 0; i < dep[k]; i++) begin
                  ms[k][i] = din;
                  mv[k][i] = din_valid;
               end
               RO: begin
                  td = ms[k][dep[k]-1];
                  tv = mv[k][dep[k]-1];
                  for (int i = dep[k] - 1; i > 0; i--) begin
                     ms[k][i] = ms[k][i-1];
                     mv[k][i] = mv[k][i-1];
                  end
                  ms[k][0] = td;
                  mv[k][0] = tv;
               end
               default: ;
            endcase
         end
      end
   endtask

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic check_inst(input int k, input string nm, input logic [7:0] d, input logic dvv,
                             input logic [7:0] t, input logic tvv, input logic [31:0] c, input int ts);
      int n;
      n = 0;
      for (int i = 0; i < dep[k]; i++) n += int'(mv[k][i]);
      cmp({nm, "_dout"}, 32'(d), 32'(ms[k][dep[k]-1]));
      cmp({nm, "_dout_valid"}, 32'(dvv), 32'(mv[k][dep[k]-1]));
      cmp({nm, "_count"}, c, 32'(n));
      if (ts < dep[k]) begin
         cmp({nm, "_tap"}, 32'(t), 32'(ms[k][ts]));
         cmp({nm, "_tap_valid"}, 32'(tvv), 32'(mv[k][ts]));
      end else begin
         cmp({nm, "_tap_oor"}, 32'(t), 32'h0);
         cmp({nm, "_tap_valid_oor"}, 32'(tvv), 32'h0);
      end
   endtask

   task automatic check_model();
      check_inst(0, "d4", dout4, dv4, tap4, tv4, 32'(cnt4), int'(tsel4));
      check_inst(1, "d3", dout3, dv3, tap3, tv3, 32'(cnt3), int'(tsel3));
      check_inst(2, "d1", dout1, dv1, tap1, tv1, 32'(cnt1), int'(tsel1));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_in(input logic c, input logic e, input logic [1:0] m,
                         input logic [7:0] d, input logic dvv, input logic [1:0] ts);
      clr = c; en = e; mode = m; din = d; din_valid = dvv;
      tsel4 = ts; tsel3 = ts; tsel1 = ts[0];
   endtask

   initial begin
      tbl[0]  = '{1'b0, 1'b1, SH, 8'h11, 1'b1, 2'd0, 8'h00, 1'b0, 8'h11, 1'b1, 1};
      tbl[1]  = '{1'b0, 1'b1, SH, 8'h22, 1'b1, 2'd1, 8'h00, 1'b0, 8'h11, 1'b1, 2};
      tbl[2]  = '{1'b0, 1'b1, SH, 8'h33, 1'b1, 2'd2, 8'h00, 1'b0, 8'h11, 1'b1, 3};
      tbl[3]  = '{1'b0, 1'b1, SH, 8'h44, 1'b1, 2'd0, 8'h11, 1'b1, 8'h44, 1'b1, 4};
      tbl[4]  = '{1'b0, 1'b1, RO, 8'hFF, 1'b0, 2'd0, 8'h22, 1'b1, 8'h11, 1'b1, 4};
      tbl[5]  = '{1'b0, 1'b1, RO, 8'hFF, 1'b0, 2'd1, 8'h33, 1'b1, 8'h11, 1'b1, 4};
      tbl[6]  = '{1'b0, 1'b1, RO, 8'hFF, 1'b0, 2'd2, 8'h44, 1'b1, 8'h11, 1'b1, 4};
      tbl[7]  = '{1'b0, 1'b1, RO, 8'hFF, 1'b0, 2'd3, 8'h11, 1'b1, 8'h11, 1'b1, 4};
      tbl[8]  = '{1'b0, 1'b1, SH, 8'h55, 1'b0, 2'd0, 8'h22, 1'b1, 8'h55, 1'b0, 3};
      tbl[9]  = '{1'b0, 1'b1, HO, 8'h99, 1'b1, 2'd0, 8'h22, 1'b1, 8'h55, 1'b0, 3};
      tbl[10] = '{1'b0, 1'b1, LD, 8'hA5, 1'b1, 2'd2, 8'hA5, 1'b1, 8'hA5, 1'b1, 4};
      tbl[11] = '{1'b0, 1'b0, SH, 8'hFF, 1'b0, 2'd1, 8'hA5, 1'b1, 8'hA5, 1'b1, 4};
      tbl[12] = '{1'b0, 1'b0, SH, 8'hFF, 1'b0, 2'd3, 8'hA5, 1'b1, 8'hA5, 1'b1, 4};
      tbl[13] = '{1'b0, 1'b0, SH, 8'hFF, 1'b0, 2'd0, 8'hA5, 1'b1, 8'hA5, 1'b1, 4};
      tbl[14] = '{1'b1, 1'b0, LD, 8'h77, 1'b1, 2'd2, 8'h00, 1'b0, 8'h00, 1'b0, 0};
      tbl[15] = '{1'b0, 1'b1, SH, 8'h66, 1'b1, 2'd0, 8'h00, 1'b0, 8'h66, 1'b1, 1};
      tbl[16] = '{1'b0, 1'b1, LD, 8'hC3, 1'b1, 2'd1, 8'hC3, 1'b1, 8'hC3, 1'b1, 4};
      tbl[17] = '{1'b1, 1'b1, SH, 8'h12, 1'b1, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 0};
      tbl[18] = '{1'b0, 1'b1, LD, 8'h5A, 1'b0, 2'd3, 8'h5A, 1'b0, 8'h5A, 1'b0, 0};

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_model();
      rst_n = 1'b1;

      // Fill the pipeline, then assert reset mid-cycle.
      for (int i = 1; i <= 4; i++) begin
         set_in(1'b0, 1'b1, SH, 8'(i * 8'h11), 1'b1, 2'd0);
         tick();
         check_model();
      end
      cmp("prefill_count", 32'(cnt4), 32'd4);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      cmp("async_rst_dout", 32'(dout4), 32'h00);
      cmp("async_rst_dout_valid", 32'(dv4), 32'h0);
      cmp("async_rst_count", 32'(cnt4), 32'h0);
      cmp("async_rst_tap", 32'(tap4), 32'h00);
      check_model();
      repeat (2) begin
         tick();
         cmp("rst_hold_dout", 32'(dout4), 32'h00);
         cmp("rst_hold_count", 32'(cnt4), 32'h0);
         check_model();
      end
      rst_n = 1'b1;

      for (int r = 0; r < 19; r++) begin
         set_in(tbl[r].c, tbl[r].e, tbl[r].m, tbl[r].d, tbl[r].dv, tbl[r].ts);
         tick();
         cmp($sformatf("vec%0d_dout", r), 32'(dout4), 32'(tbl[r].x_dout));
         cmp($sformatf("vec%0d_dout_valid", r), 32'(dv4), 32'(tbl[r].x_dv));
         cmp($sformatf("vec%0d_tap", r), 32'(tap4), 32'(tbl[r].x_tap));
         cmp($sformatf("vec%0d_tap_valid", r), 32'(tv4), 32'(tbl[r].x_tv));
         cmp($sformatf("vec%0d_count", r), 32'(cnt4), 32'(tbl[r].x_cnt));
         check_model();
      end

      // DEPTH=3 out-of-range tap, DEPTH=1 shift then rotate.
      set_in(1'b0, 1'b1, LD, 8'h81, 1'b1, 2'd3);
      tick();
      cmp("d3_tap_oor", 32'(tap3), 32'h00);
      cmp("d3_tap_valid_oor", 32'(tv3), 32'h0);
      cmp("d3_dout_load", 32'(dout3), 32'h81);
      set_in(1'b1, 1'b1, HO, 8'h00, 1'b0, 2'd0);
      tick();
      cmp("d1_clr_dout", 32'(dout1), 32'hC5);
      set_in(1'b0, 1'b1, SH, 8'h7E, 1'b1, 2'd0);
      tick();
      cmp("d1_shift_dout", 32'(dout1), 32'h7E);
      cmp("d1_shift_valid", 32'(dv1), 32'h1);
      cmp("d1_shift_count", 32'(cnt1), 32'h1);
      set_in(1'b0, 1'b1, RO, 8'h00, 1'b0, 2'd1);
      repeat (2) begin
         tick();
         cmp("d1_rotate_dout", 32'(dout1), 32'h7E);
         cmp("d1_rotate_valid", 32'(dv1), 32'h1);
         cmp("d1_tap_oor", 32'(tap1), 32'h00);
         check_model();
      end

      for (int n = 0; n < 400; n++) begin
         set_in(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), 2'($urandom_range(0, 3)));
         if ($urandom_range(0, 39) == 0) begin
            rst_n = 1'b0;
            model_reset();
            #1;
            check_model();
            rst_n = 1'b1;
         end
         tick();
         check_model();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
